exc_unit: RTL and testbench
===========================

EXC_UNIT -- requirements
Module: exc_unit

Interface
REQ-001 Parameter NUM_SRC, 3, number of exception source lines (1..16).
REQ-002 Parameter NEST_DEPTH, 2, EPC stack depth, i.e. maximum nesting level (1..8).
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port enable  in  1  qualifies coprocessor access (move-to, move-from, eret) by the current instruction.
REQ-006 Port exp_src  in  NUM_SRC  exception request lines, bit i = source i, sampled each clock.
REQ-007 Port inst  in  32  current instruction word.
REQ-008 Port pc_in  in  32  PC to save on exception entry.
REQ-009 Port din  in  32  write data for move-to-coprocessor.
REQ-010 Port is_eret  out  1  combinational: inst[5:0] == 6'b000110.
REQ-011 Port has_exp  out  1  registered one-cycle pulse, exception taken.
REQ-012 Port ex_reg_write  out  1  combinational: !inst[23].
REQ-013 Port exp_block  out  1  registered-state-derived: new exceptions currently not acceptable.
REQ-014 Port pc_out  out  32  top-of-stack EPC, or 0 when the stack is empty.
REQ-015 Port dout  out  32  combinational register read data selected by inst[12:11].

Function
REQ-016 The block SHALL decode sel = inst[12:11]: 00 EPC, 01 Status, 10 Mask, 11 Cause.
REQ-017 A software write SHALL occur when enable && !ex_reg_write, to the register selected by sel.
REQ-018 An eret event SHALL be enable && is_eret && ex_reg_write.
REQ-019 pending[NUM_SRC-1:0] SHALL set bit i on any clock with exp_src[i]=1, and hold regardless of mask or block state.
REQ-020 A pending bit SHALL clear only when its source is taken; set takes priority when both occur on the same cycle.
REQ-021 eligible SHALL equal pending & Mask[NUM_SRC-1:0].
REQ-022 exp_block SHALL equal (Status[0] && !Status[1]) || (depth == NEST_DEPTH).
REQ-023 A take SHALL occur on a clock where |eligible && !exp_block && no eret event.
REQ-024 On a take, the selected source SHALL be the lowest-index eligible bit, giving fixed priority with bit 0 highest.
REQ-025 Take effects, all on the same edge: push pc_in onto the EPC stack; depth+1; Status[0] set; Cause set to index+1 in bits [4:0] with the upper bits 0; the taken pending bit cleared; has_exp = 1 for exactly the next cycle.
REQ-026 On an eret event with depth > 0, the block SHALL pop the stack and decrement depth; Status[0] SHALL clear when the new depth is 0.
REQ-027 An eret event with depth == 0 SHALL have no state effect.
REQ-028 Eret and take on the same cycle: eret SHALL win; the take is re-evaluated next cycle with pending unchanged.
REQ-029 A write to EPC SHALL overwrite the top-of-stack entry, or entry 0 if depth == 0, without changing depth.
REQ-030 Writes to Status SHALL affect bits [1:0] only; bit0 = block (EXL), bit1 = nest-enable.
REQ-031 Writes to Mask SHALL affect bits [NUM_SRC-1:0] only.
REQ-032 Writes to Cause SHALL be ignored.
REQ-033 A take SHALL override a same-cycle software write to EPC or Status.
REQ-034 Status reads SHALL return {16'b0, 4'b0, depth in [11:8], 6'b0, Status[1:0]}, with depth zero-extended.
REQ-035 Mask reads SHALL return the Mask zero-extended; EPC reads SHALL return pc_out.
REQ-036 Pending exceptions blocked by full depth SHALL remain pending and be taken once depth drops.

Reset
REQ-037 While rst_n = 0: pending, Mask, Status, Cause, depth, all stack entries and has_exp SHALL be 0.
REQ-038 Reset SHALL take effect immediately on assertion, independent of clk.
REQ-039 Reset asserted mid-handler SHALL discard the entire stack and abandon any in-flight has_exp pulse.
REQ-040 Consequence of reset: pc_out = 0 and exp_block = 0; no take is possible until Mask is written, since Mask resets to 0.

Verification
REQ-041 Write Mask = 3'b111, pulse exp_src = 3'b110 for one cycle with pc_in = 0x100 -> has_exp pulses once; Cause = 2; pc_out = 0x100; Status reads 0x101; pending = 3'b100.
REQ-042 Continue from REQ-041 with an eret -> depth 0, Status[0] = 0; the next cycle takes source 2 with Cause = 3.
REQ-043 Status = 2'b11, NEST_DEPTH = 2: takes at pc 0x10, 0x20, then a third request -> exp_block = 1, the third stays pending; eret -> pc_out goes 0x20 -> 0x10; the third is taken at the next cycle.
REQ-044 Eret and an eligible request on the same cycle -> the pop happens with no has_exp that cycle; has_exp follows one cycle later.
REQ-045 Mask = 0, exp_src pulsed -> no take; later Mask = 1 -> take occurs from the latched pending bit.
REQ-046 rst_n asserted between clock edges at depth 2 -> all outputs 0 immediately; eret after reset -> no effect.

Source files
------------

// File: rtl/exc_unit.sv
// Exception unit: latches exception requests, takes the highest-priority
// eligible one into a nested EPC stack, and exposes the EPC/Status/Mask/Cause
// registers to move-to / move-from / eret instructions.
module exc_unit #(
    parameter int NUM_SRC    = 3,
    parameter int NEST_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] exp_src,
    input  logic [31:0]        inst,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        din,
    output logic               is_eret,
    output logic               has_exp,
    output logic               ex_reg_write,
    output logic               exp_block,
    output logic [31:0]        pc_out,
    output logic [31:0]        dout
);

    // Depth counts 0..NEST_DEPTH (max 8) and is reported in a 4-bit field.
    localparam int DEPTH_W = 4;

    typedef enum logic [1:0] {
        SEL_EPC    = 2'b00,
        SEL_STATUS = 2'b01,
        SEL_MASK   = 2'b10,
        SEL_CAUSE  = 2'b11
    } sel_e;

    // Architectural state.
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [1:0]         status;     // [0] = EXL (block), [1] = nest-enable
    logic [4:0]         cause;
    logic [DEPTH_W-1:0] depth;
    logic [31:0]        stack [NEST_DEPTH];

    // Decoded controls.
    sel_e               sel;
    logic               sw_write;
    logic               eret_ev;
    logic               pop;
    logic [NUM_SRC-1:0] eligible;
    logic               take;
    logic [NUM_SRC-1:0] take_onehot;
    logic [4:0]         take_cause;
    logic [DEPTH_W-1:0] epc_idx;

    // Instruction fields this block does not decode.
    logic inst_unused;
    assign inst_unused = ^{inst[31:24], inst[22:13], inst[10:6]};

    assign is_eret      = (inst[5:0] == 6'b000110);
    assign ex_reg_write = !inst[23];
    assign sel          = sel_e'(inst[12:11]);
    // A move-to and an eret are mutually exclusive because they need
    // opposite values of inst[23].
    assign sw_write     = enable && !ex_reg_write;
    assign eret_ev      = enable && is_eret && ex_reg_write;
    assign pop          = eret_ev && (depth != '0);

    assign exp_block = (status[0] && !status[1]) ||
                       (depth == DEPTH_W'(NEST_DEPTH));
    assign eligible  = pending & mask;
    assign take      = (|eligible) && !exp_block && !eret_ev;

    // EPC software writes land on the top entry, or entry 0 when empty.
    assign epc_idx = (depth == '0) ? '0 : depth - DEPTH_W'(1);

    // Fixed-priority select: scanning high to low lets the lowest index win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        take_onehot = '0;
        take_cause  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                take_onehot    = '0;
                take_onehot[i] = 1'b1;
                take_cause     = 5'(i + 1);
            end
        end
    end

    // Top-of-stack EPC, zero when nothing is stacked.
    always_comb begin
        pc_out = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if ((depth != '0) && (DEPTH_W'(i) == depth - DEPTH_W'(1))) begin
                pc_out = stack[i];
            end
        end
    end

    // Register read mux.
    always_comb begin
        dout = '0;
        case (sel)
            SEL_EPC:    dout = pc_out;
            SEL_STATUS: dout = {20'b0, depth, 6'b0, status};
            SEL_MASK:   dout = 32'(mask);
            SEL_CAUSE:  dout = {27'b0, cause};
            default:    dout = '0;
        endcase
    end

    // Pending latch: a new request wins over clearing the bit being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(take ? take_onehot : '0)) | exp_src;
        end
    end

    // Mask register: software writable, unaffected by takes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (sw_write && (sel == SEL_MASK)) begin
            mask <= din[NUM_SRC-1:0];
        end
    end

    // Status register: take sets EXL, the last eret clears it, software
    // writes only when no take is happening on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else if (take) begin
            status[0] <= 1'b1;
        end else if (pop && (depth == DEPTH_W'(1))) begin
            status[0] <= 1'b0;
        end else if (sw_write && (sel == SEL_STATUS)) begin
            status <= din[1:0];
        end
    end

    // Cause register: hardware-only, records index+1 of the taken source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause <= '0;
        end else if (take) begin
            cause <= take_cause;
        end
    end

    // Nesting depth: take and pop never coincide since eret blocks a take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (take) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // EPC stack: push on take, otherwise software may overwrite the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stack is a small flop array that must read as zero
            // after reset, so every entry is cleared here rather than left
            // as uninitialised RAM.
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (take && (DEPTH_W'(i) == depth)) begin
                    stack[i] <= pc_in;
                end else if (!take && sw_write && (sel == SEL_EPC) &&
                             (DEPTH_W'(i) == epc_idx)) begin
                    stack[i] <= din;
                end
            end
        end
    end

    // Exception-taken pulse, high for the cycle after a take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_exp <= 1'b0;
        end else begin
            has_exp <= take;
        end
    end

endmodule

// File: tb/tb_exc_unit.sv
// Testbench for exc_unit: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the unit.
module tb_exc_unit;

    localparam int NUM_SRC    = 3;
    localparam int NEST_DEPTH = 2;
    localparam logic [31:0] ERET = 32'h0000_0006;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               enable  = 1'b0;
    logic [NUM_SRC-1:0] exp_src = '0;
    logic [31:0]        inst    = '0;
    logic [31:0]        pc_in   = '0;
    logic [31:0]        din     = '0;
    logic               is_eret;
    logic               has_exp;
    logic               ex_reg_write;
    logic               exp_block;
    logic [31:0]        pc_out;
    logic [31:0]        dout;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [NUM_SRC-1:0] m_pending;
    logic [NUM_SRC-1:0] m_mask;
    logic [1:0]         m_status;
    logic [4:0]         m_cause;
    bit                 m_has;
    logic [31:0]        m_stk [$];

    exc_unit #(
        .NUM_SRC    (NUM_SRC),
        .NEST_DEPTH (NEST_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .exp_src      (exp_src),
        .inst         (inst),
        .pc_in        (pc_in),
        .din          (din),
        .is_eret      (is_eret),
        .has_exp      (has_exp),
        .ex_reg_write (ex_reg_write),
        .exp_block    (exp_block),
        .pc_out       (pc_out),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rd(input int s);
        return 32'(s) << 11;
    endfunction

    function automatic logic [31:0] wr(input int s);
        return 32'h0080_0000 | (32'(s) << 11);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = '0;
        m_mask    = '0;
        m_status  = '0;
        m_cause   = '0;
        m_has     = 1'b0;
        m_stk.delete();
    endtask

    // Apply inputs at the falling edge, compare outputs against the model,
    // advance the model by one clock, then move to the next falling edge.
    task automatic step(input logic en, input logic [NUM_SRC-1:0] src,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] d);
        logic [1:0]         sel;
        logic [31:0]        top;
        logic [31:0]        exp_dout;
        logic [NUM_SRC-1:0] elig;
        bit                 blk, wr_ev, er_ev, take;
        int                 depth, idx;
        enable  = en;
        exp_src = src;
        inst    = ins;
        pc_in   = pc;
        din     = d;
        #1;
        sel   = ins[12:11];
        depth = m_stk.size();
        top   = (depth > 0) ? m_stk[depth-1] : 32'h0;
        blk   = (m_status[0] && !m_status[1]) || (depth == NEST_DEPTH);
        case (sel)
            2'd0:    exp_dout = top;
            2'd1:    exp_dout = (32'(depth) << 8) | 32'(m_status);
            2'd2:    exp_dout = 32'(m_mask);
            default: exp_dout = 32'(m_cause);
        endcase
        check("is_eret", is_eret, ins[5:0] == 6'd6);
        check("ex_reg_write", ex_reg_write, !ins[23]);
        check("has_exp", has_exp, m_has);
        check("exp_block", exp_block, blk);
        check("pc_out", pc_out, top);
        check("dout", dout, exp_dout);

        wr_ev = en && ins[23];
        er_ev = en && !ins[23] && (ins[5:0] == 6'd6);
        elig  = m_pending & m_mask;
        take  = (elig != '0) && !blk && !er_ev;
        idx   = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) idx = i;
        end
        // An EPC write with an empty stack is invisible: pc_out reads 0 and
        // the next push overwrites that entry.
        if (wr_ev && !take && sel == 2'd0 && depth > 0) m_stk[depth-1] = d;
        if (wr_ev && !take && sel == 2'd1) m_status = d[1:0];
        if (wr_ev && sel == 2'd2) m_mask = d[NUM_SRC-1:0];
        if (take) begin
            m_stk.push_back(pc);
            m_status[0]    = 1'b1;
            m_cause        = 5'(idx + 1);
            m_pending[idx] = 1'b0;
        end else if (er_ev && depth > 0) begin
            void'(m_stk.pop_back());
            if (m_stk.size() == 0) m_status[0] = 1'b0;
        end
        m_pending = m_pending | src;
        m_has     = take;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Read a register without clocking and compare with a fixed value.
    task automatic read_expect(input int s, input string tag, input logic [31:0] exp);
        enable  = 1'b0;
        exp_src = '0;
        inst    = rd(s);
        #1;
        check(tag, dout, exp);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_has_exp", has_exp, 1'b0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_exp_block", exp_block, 1'b0);
        read_expect(1, "rst_status", 32'h0);
        read_expect(2, "rst_mask", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single take with priority: sources 1 and 2 requested together.
        step(1, 3'b000, wr(2), 32'h0, 32'h7);
        step(0, 3'b110, rd(0), 32'h100, 32'h0);
        step(0, 3'b000, rd(0), 32'h100, 32'h0);
        check("take1_has_exp", has_exp, 1'b1);
        read_expect(3, "take1_cause", 32'h2);
        read_expect(0, "take1_epc", 32'h100);
        read_expect(1, "take1_status", 32'h101);
        step(0, 3'b000, rd(1), 32'h200, 32'h0);
        check("take1_pulse_end", has_exp, 1'b0);

        // Return, then the still-pending source 2 is taken.
        step(1, 3'b000, ERET, 32'h300, 32'h0);
        read_expect(1, "eret1_status", 32'h0);
        step(0, 3'b000, rd(3), 32'h300, 32'h0);
        check("take2_has_exp", has_exp, 1'b1);
        read_expect(3, "take2_cause", 32'h3);
        step(1, 3'b000, ERET, 32'h0, 32'h0);

        // Nesting to full depth; the third request waits for a return.
        step(1, 3'b000, wr(1), 32'h0, 32'h3);
        step(0, 3'b001, rd(0), 32'h0, 32'h0);
        step(0, 3'b001, rd(0), 32'h10, 32'h0);
        step(0, 3'b001, rd(0), 32'h20, 32'h0);
        step(0, 3'b000, rd(0), 32'h30, 32'h0);
        check("nest_block", exp_block, 1'b1);
        check("nest_top", pc_out, 32'h20);
        check("nest_no_take", has_exp, 1'b0);
        step(1, 3'b000, ERET, 32'h38, 32'h0);
        check("nest_pop", pc_out, 32'h10);
        check("nest_pop_no_take", has_exp, 1'b0);
        step(0, 3'b000, rd(1), 32'h40, 32'h0);
        check("nest_third", has_exp, 1'b1);
        check("nest_third_pc", pc_out, 32'h40);

        // Eret wins over a same-cycle eligible request.
        step(1, 3'b000, ERET, 32'h0, 32'h0);
        step(0, 3'b010, rd(0), 32'h0, 32'h0);
        step(1, 3'b000, ERET, 32'h50, 32'h0);
        check("race_no_take", has_exp, 1'b0);
        check("race_popped", pc_out, 32'h0);
        step(0, 3'b000, rd(3), 32'h58, 32'h0);
        check("race_late_take", has_exp, 1'b1);
        read_expect(3, "race_cause", 32'h2);
        step(1, 3'b000, ERET, 32'h0, 32'h0);

        // Masked request stays latched until the mask opens.
        step(1, 3'b000, wr(2), 32'h0, 32'h0);
        step(0, 3'b001, rd(0), 32'h0, 32'h0);
        step(0, 3'b000, rd(0), 32'h0, 32'h0);
        check("masked_no_take", has_exp, 1'b0);
        step(1, 3'b000, wr(2), 32'h0, 32'h1);
        step(0, 3'b000, rd(0), 32'h60, 32'h0);
        check("unmask_take", has_exp, 1'b1);
        read_expect(3, "unmask_cause", 32'h1);

        // Asynchronous reset between edges at depth 2 with a pulse in flight.
        step(0, 3'b001, rd(0), 32'h0, 32'h0);
        step(0, 3'b000, rd(1), 32'h70, 32'h0);
        check("pre_rst_pulse", has_exp, 1'b1);
        check("pre_rst_top", pc_out, 32'h70);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_has_exp", has_exp, 1'b0);
        check("arst_pc_out", pc_out, 32'h0);
        check("arst_exp_block", exp_block, 1'b0);
        check("arst_status", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'b000, ERET, 32'h0, 32'h0);
        check("post_rst_eret_pc", pc_out, 32'h0);
        read_expect(1, "post_rst_eret_status", 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [NUM_SRC-1:0] src;
            case ($urandom_range(0, 4))
                0:       ins = rd($urandom_range(0, 3));
                1:       ins = wr($urandom_range(0, 3));
                2:       ins = ERET;
                3:       ins = ERET | rd($urandom_range(0, 3));
                default: ins = $urandom;
            endcase
            src = ($urandom_range(0, 2) == 0) ? NUM_SRC'($urandom) : '0;
            step($urandom_range(0, 3) != 0, src, ins, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
